// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access unit; turns loads/stores into a
// single-beat req/ack bus transaction, stalls the pipeline and extends load data.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [2:0]  MEM_DMType,
    input  logic [31:0] MEM_aluout,
    input  logic [31:0] MEM_rs2data,
    input  logic        INT_detected,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        mem_stall,
    output logic [31:0] MEM_Data_in,
    output logic        misalign,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_kill;
    logic             r_is_load;
    logic [2:0]       r_dmtype;
    logic [1:0]       r_off;

    logic        w_half, w_byte, w_aligned, w_req, w_access, w_misal, w_issue;
    logic        w_timeout, w_kill;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_lane8;
    logic [15:0] w_lane16;

    // Stores only know 001 (half) and 011 (byte); every other store code is a word.
    assign w_half    = (MEM_DMType == 3'b001) | (!MEM_MemWrite & MEM_DMType == 3'b010);
    assign w_byte    = (MEM_DMType == 3'b011) | (!MEM_MemWrite & MEM_DMType == 3'b100);
    assign w_aligned = w_byte | (w_half ? !MEM_aluout[0] : MEM_aluout[1:0] == 2'b00);
    assign w_req     = MEM_MemRead | MEM_MemWrite;
    assign w_access  = w_req & w_aligned;
    assign w_misal   = w_req & !w_aligned;
    assign w_issue   = (r_state == IDLE) & w_access & !INT_detected;
    assign mem_stall = w_issue | (r_state == WAIT);

    assign w_be    = w_byte ? 4'b0001 << MEM_aluout[1:0] :
                     w_half ? (MEM_aluout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_byte ? {4{MEM_rs2data[7:0]}} :
                     w_half ? {2{MEM_rs2data[15:0]}} : MEM_rs2data;

    assign w_lane8     = bus_rdata[{r_off, 3'b000} +: 8];
    assign w_lane16    = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign w_load_data = (r_dmtype == 3'b011) ? {{24{w_lane8[7]}}, w_lane8} :
                         (r_dmtype == 3'b100) ? {24'd0, w_lane8} :
                         (r_dmtype == 3'b001) ? {{16{w_lane16[15]}}, w_lane16} :
                         (r_dmtype == 3'b010) ? {16'd0, w_lane16} : bus_rdata;

    assign w_timeout = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_kill    = r_kill | INT_detected;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_is_load   <= 1'b0;
            r_dmtype    <= 3'd0;
            r_off       <= 2'd0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_be      <= 4'd0;
            bus_wdata   <= 32'd0;
            MEM_Data_in <= 32'd0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MEM_MemWrite;
                        bus_addr  <= {MEM_aluout[31:2], 2'b00};
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                        r_is_load <= !MEM_MemWrite;
                        r_dmtype  <= MEM_DMType;
                        r_off     <= MEM_aluout[1:0];
                        r_cnt     <= '0;
                        r_state   <= WAIT;
                    end else if (w_misal & !INT_detected) begin
                        misalign <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (INT_detected) r_kill <= 1'b1;
                    // A flushed access still completes on the bus but never writes back.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_kill  <= 1'b0;
                        if (r_is_load & !w_kill) MEM_Data_in <= w_load_data;
                        r_state <= w_kill ? IDLE : DONE;
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_kill  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Data-memory access unit for the MEM stage of the 5-stage pipeline. It sits between the EX/MEM register and the MEM/WB register, and drives the MEM_Data_in value that MEM/WB latches. It converts load/store instructions into a single-beat req/ack bus transaction with byte enables and stalls the pipeline while the access is outstanding. It also sign- or zero-extends load data, detects misaligned accesses, and enforces a bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT without bus_ack before the access is aborted with bus_err.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
MEM_MemRead  in  1  load instruction present in MEM.
MEM_MemWrite  in  1  store instruction present in MEM.
MEM_DMType  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Stores use 000, 001 or 011; other codes are treated as word.
MEM_aluout  in  32  effective byte address.
MEM_rs2data  in  32  store data, right-aligned.
INT_detected  in  1  flush request; same signal that drives MEM/WB.
bus_rdata  in  32  read data, valid with bus_ack.
bus_ack  in  1  one-cycle transaction completion.
bus_req  out  1  registered; transaction request.
bus_we  out  1  registered; 1 = write.
bus_addr  out  32  registered; {MEM_aluout[31:2], 2'b00}.
bus_be  out  4  registered byte enables.
bus_wdata  out  32  registered, lane-replicated store data.
mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
MEM_Data_in  out  32  registered, extended load result to MEM/WB.
misalign  out  1  registered one-cycle fault pulse.
bus_err  out  1  registered one-cycle timeout pulse.

Behaviour:
- Reset values: every registered output is 0. state=IDLE, counter=0, kill=0.
- Alignment check:
  - Word access is misaligned when addr[1:0]!=0.
  - Half access is misaligned when addr[0]!=0.
  - Byte access is always aligned.
- access = (MEM_MemRead | MEM_MemWrite) & aligned. If both MemRead and MemWrite are set, the access is a write.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If access & !INT_detected: load the bus_* registers, set bus_req=1, go to WAIT, clear the counter.
  - If misaligned & !INT_detected: pulse misalign, no bus activity, stay in IDLE.
- WAIT:
  - bus_req, bus_addr, bus_we, bus_be and bus_wdata hold stable.
  - Counter increments each cycle.
  - On bus_ack: drop bus_req. For a load, capture the extended bus_rdata into MEM_Data_in. Go to DONE, or to IDLE if kill=1.
  - On counter==TIMEOUT_CYCLES-1 without ack: drop bus_req, pulse bus_err, go to DONE with MEM_Data_in unchanged.
- DONE: go to IDLE unconditionally. Clear kill.
- mem_stall = (state==IDLE & access & !INT_detected) | (state==WAIT). It is 0 in DONE, so the pipeline advances on the DONE edge and MEM/WB captures MEM_Data_in.
- Minimum latency: an instruction entering MEM at cycle 0 with bus_ack at cycle 1 leaves MEM at the end of cycle 2 (2 stall cycles). Each extra wait cycle adds one.
- Store lanes, with k = addr[1:0]:
  - Byte: be = 1<<k; wdata = the byte replicated in all 4 lanes.
  - Half: be = 0011 (k=0) or 1100 (k=2); wdata = the half replicated.
  - Word: be = 1111.
- Load extraction: select the lane addressed by addr[1:0], then sign-extend for codes 001/011 or zero-extend for 010/100.
- MEM_Data_in changes only on load completion. Stores, faults and timeouts leave it unchanged.
- INT_detected:
  - In IDLE or DONE: no new request is issued; state goes to IDLE.
  - In WAIT: the transaction is not abandoned; kill is set, and on ack the state returns to IDLE without updating MEM_Data_in.
- Simultaneous bus_ack and timeout in the same cycle: ack wins, no bus_err.
- Reset mid-WAIT: bus_req drops immediately (asynchronous), all state is cleared, and the transaction is abandoned.

Test Plan:
- lw at addr 0x100, rdata=0xDEADBEEF, ack in cycle 1 -> bus_req high for 1 cycle, bus_be=1111, mem_stall high for cycles 0-1, MEM_Data_in=0xDEADBEEF in cycle 2.
- lb at 0x103, rdata=0x80FF0000 -> MEM_Data_in=0xFFFFFF80. Same access as lbu -> 0x00000080. lh at 0x102 -> 0xFFFF80FF.
- sb at 0x101, rs2=0x000000AB -> bus_we=1, bus_be=0010, bus_wdata=0xABABABAB. sh at 0x102, rs2=0x1234 -> be=1100, wdata=0x12341234.
- lw at 0x102 -> misalign pulses 1 cycle, bus_req stays 0, mem_stall stays 0, MEM_Data_in unchanged.
- Load with no ack, TIMEOUT_CYCLES=16 -> bus_req drops after 16 WAIT cycles, bus_err pulses, mem_stall deasserts.
- INT_detected in WAIT, ack 3 cycles later -> bus_req holds until ack, MEM_Data_in unchanged, state returns to IDLE. Separately, async reset asserted mid-WAIT -> all outputs 0 in the same cycle.
